// File: rtl/tone_sequencer_pkg.sv
// Shared types and defaults for the tone sequencer.
// Contents: sequencer state enum, table entry struct, default prescale/gap.
// The entry struct fields are sized by ENTRY_FREQ_W / ENTRY_DUR_W; the top's
// freq_width / dur_width parameters must not exceed these.
package tone_sequencer_pkg;

  localparam int unsigned ENTRY_FREQ_W       = 16;
  localparam int unsigned ENTRY_DUR_W        = 16;
  localparam int unsigned TICK_DIV_DEFAULT   = 50000;
  localparam int unsigned GAP_CYCLES_DEFAULT = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  // One playback table entry; dur = 0 marks end of sequence.
  typedef struct packed {
    logic [ENTRY_FREQ_W-1:0] freq;
    logic                    wave;
    logic [ENTRY_DUR_W-1:0]  dur;
  } tone_entry_t;

endpackage

// File: rtl/tone_sequencer_tick_prescaler.sv
// tick_prescaler: free-running counter modulo TICK_DIV.
// Ports: clock, reset (async, active-high), clear (sync, restarts the count),
//        tick (registered, high for the one cycle in which the count is TICK_DIV-1).
// After clear, the first tick arrives exactly TICK_DIV cycles later.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Next count value, wrapping at TICK_DIV-1.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  // Tick is registered from the next count so it aligns with count == TICK_DIV-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == CNT_LAST);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: timed playback of a small (freq, waveform, duration) table
// into the CORDIC generator's freq / waveform_sel inputs, with a silent gap
// between tones.
// Ports: clock, reset (async, active-high); table write port wr_en/wr_addr/
//        wr_freq/wr_wave/wr_dur; controls start/stop/loop; registered outputs
//        freq, waveform_sel, tone_active, busy, done, cur_idx.
// Build option: define TONE_SEQ_LOOP_EN to honour the loop input; otherwise
//               loop is ignored and every sequence ends in DONE.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int unsigned freq_width = ENTRY_FREQ_W,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned dur_width  = ENTRY_DUR_W,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [freq_width-1:0]    wr_freq,
  input  logic                     wr_wave,
  input  logic [dur_width-1:0]     wr_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [freq_width-1:0]    freq,
  output logic                     waveform_sel,
  output logic                     tone_active,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  seq_state_t       state;
  tone_entry_t      table_q [DEPTH];
  tone_entry_t      rd_entry;
  logic [dur_width-1:0] dur_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             tick;
  logic             loop_en;

  // Advance-step decision shared by the PLAY (no gap) and GAP exits.
  seq_state_t       adv_state;
  logic [IDX_W-1:0] adv_idx;
  logic             adv_done;

`ifdef TONE_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  // Table write port; contents deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      table_q[wr_addr] <= '{freq: ENTRY_FREQ_W'(wr_freq),
                            wave: wr_wave,
                            dur:  ENTRY_DUR_W'(wr_dur)};
    end
  end

  assign rd_entry = table_q[cur_idx];

  // Prescaler restarts during LOAD so PLAY starts on a clean tick boundary.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (state == ST_LOAD),
    .tick  (tick)
  );

  // Next entry after a tone finishes: increment, wrap on loop, or finish.
  always_comb begin
    adv_state = ST_LOAD;
    adv_idx   = cur_idx + IDX_W'(1);
    adv_done  = 1'b0;
    if (cur_idx == LAST_IDX) begin
      adv_idx = '0;
      if (!loop_en) begin
        adv_state = ST_DONE;
        adv_idx   = cur_idx;
        adv_done  = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs; stop overrides everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur_idx      <= '0;
      freq         <= '0;
      waveform_sel <= 1'b1;
      tone_active  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dur_cnt      <= '0;
      gap_cnt      <= '0;
    end else if (stop && (state != ST_IDLE)) begin
      state       <= ST_IDLE;
      freq        <= '0;
      tone_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            cur_idx <= '0;
            busy    <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (rd_entry.dur != '0) begin
            state        <= ST_PLAY;
            freq         <= freq_width'(rd_entry.freq);
            waveform_sel <= rd_entry.wave;
            tone_active  <= 1'b1;
            dur_cnt      <= dur_width'(rd_entry.dur);
          end else if (loop_en && (cur_idx != '0)) begin
            cur_idx <= '0;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (tick) begin
            if (dur_cnt == dur_width'(1)) begin
              freq        <= '0;
              tone_active <= 1'b0;
              if (GAP_CYCLES != 0) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              end else begin
                state   <= adv_state;
                cur_idx <= adv_idx;
                done    <= adv_done;
              end
            end else begin
              dur_cnt <= dur_cnt - dur_width'(1);
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) begin
            state   <= adv_state;
            cur_idx <= adv_idx;
            done    <= adv_done;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer (TICK_DIV=4, GAP_CYCLES=2, DEPTH=4).
module tb_tone_sequencer;

  localparam int unsigned TD  = 4;
  localparam int unsigned GAP = 2;

  typedef struct packed {
    logic [15:0] freq;
    logic        wave;
    logic        act;
    logic        busy;
    logic        done;
    logic [1:0]  idx;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_freq = '0;
  logic        wr_wave = 1'b0;
  logic [15:0] wr_dur = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] freq;
  logic        waveform_sel;
  logic        tone_active;
  logic        busy;
  logic        done;
  logic [1:0]  cur_idx;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    rec_no  = 0;
  string cur_test = "init";
  obs_t  exp_q[$];
  logic  exp_wave = 1'b1;

  tone_sequencer #(
    .freq_width (16),
    .DEPTH      (4),
    .dur_width  (16),
    .TICK_DIV   (TD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_freq      (wr_freq),
    .wr_wave      (wr_wave),
    .wr_dur       (wr_dur),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .freq         (freq),
    .waveform_sel (waveform_sel),
    .tone_active  (tone_active),
    .busy         (busy),
    .done         (done),
    .cur_idx      (cur_idx)
  );

  always #5 clock = ~clock;

  function automatic obs_t observe();
    obs_t o;
    o = '{freq: freq, wave: waveform_sel, act: tone_active,
          busy: busy, done: done, idx: cur_idx};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got freq=%h wave=%b act=%b busy=%b done=%b idx=%0d, want freq=%h wave=%b act=%b busy=%b done=%b idx=%0d",
               name, got.freq, got.wave, got.act, got.busy, got.done, got.idx,
               want.freq, want.wave, want.act, want.busy, want.done, want.idx);
    end
  endtask

  // Monitor: one expected record per cycle while the scoreboard holds any.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      obs_t want;
      want = exp_q.pop_front();
      check_obs($sformatf("%s rec%0d", cur_test, rec_no), observe(), want);
      rec_no++;
    end
  end

  task automatic push_rec(input int n, input logic [15:0] f, input logic w,
                          input logic a, input logic b, input logic d,
                          input logic [1:0] idx);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{freq: f, wave: w, act: a, busy: b, done: d, idx: idx});
    end
  endtask

  // LOAD, dur*TD cycles of tone, GAP silent cycles.
  task automatic push_tone(input logic [15:0] f, input logic w, input int dur,
                           input logic [1:0] idx);
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b0, idx);
    push_rec(dur * TD, f, w, 1'b1, 1'b1, 1'b0, idx);
    push_rec(GAP, 16'h0, w, 1'b0, 1'b1, 1'b0, idx);
    exp_wave = w;
  endtask

  // Final LOAD of an end marker, DONE pulse, back to IDLE.
  task automatic push_end(input logic [1:0] idx);
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b0, idx);
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b1, idx);
    push_rec(2, 16'h0, exp_wave, 1'b0, 1'b0, 1'b0, idx);
  endtask

  task automatic write_entry(input int a, input logic [15:0] f, input logic w,
                             input logic [15:0] d);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_addr = 2'(a); wr_freq = f; wr_wave = w; wr_dur = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(posedge clock);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d records left, want 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic begin_test(input string name);
    cur_test = name;
    rec_no   = 0;
  endtask

  initial begin
    obs_t rst_obs;
    rst_obs = '{freq: 16'h0, wave: 1'b1, act: 1'b0, busy: 1'b0, done: 1'b0, idx: 2'd0};

    #23;
    check_obs("reset_state", observe(), rst_obs);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    check_obs("idle_after_reset", observe(), rst_obs);

    // Two tones then end marker.
    begin_test("two_tones");
    write_entry(0, 16'h0100, 1'b1, 16'd3);
    write_entry(1, 16'h0200, 1'b0, 16'd2);
    write_entry(2, 16'h0000, 1'b0, 16'd0);
    write_entry(3, 16'h0000, 1'b0, 16'd0);
    pulse_start();
    push_tone(16'h0100, 1'b1, 3, 2'd0);
    push_tone(16'h0200, 1'b0, 2, 2'd1);
    push_end(2'd2);
    wait_drain();

    // Full table of 1-tick tones with loop requested.
    begin_test("loop_table");
    write_entry(0, 16'h0011, 1'b1, 16'd1);
    write_entry(1, 16'h0022, 1'b0, 16'd1);
    write_entry(2, 16'h0033, 1'b1, 16'd1);
    write_entry(3, 16'h0044, 1'b0, 16'd1);
    loop = 1'b1;
    pulse_start();
    push_tone(16'h0011, 1'b1, 1, 2'd0);
    push_tone(16'h0022, 1'b0, 1, 2'd1);
    push_tone(16'h0033, 1'b1, 1, 2'd2);
    push_tone(16'h0044, 1'b0, 1, 2'd3);
`ifdef TONE_SEQ_LOOP_EN
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b0, 2'd0);
    push_rec(2, 16'h0011, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    push_rec(3, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_wave = 1'b1;
    repeat (30) @(posedge clock);
    #1 stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
`else
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b1, 2'd3);
    push_rec(2, 16'h0, exp_wave, 1'b0, 1'b0, 1'b0, 2'd3);
`endif
    wait_drain();

    // Entry 0 is an end marker: straight to DONE even with loop set.
    begin_test("empty_seq");
    write_entry(0, 16'h0123, 1'b0, 16'd0);
    pulse_start();
    push_end(2'd0);
    wait_drain();
    loop = 1'b0;

    // stop and start together during PLAY.
    begin_test("stop_start");
    write_entry(0, 16'h0500, 1'b1, 16'd3);
    write_entry(1, 16'h0000, 1'b0, 16'd0);
    pulse_start();
    push_rec(1, 16'h0, exp_wave, 1'b0, 1'b1, 1'b0, 2'd0);
    push_rec(5, 16'h0500, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    push_rec(3, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_wave = 1'b1;
    repeat (5) @(posedge clock);
    #1 begin stop = 1'b1; start = 1'b1; end
    @(posedge clock); #1;
    stop = 1'b0; start = 1'b0;
    wait_drain();

    // Asynchronous reset mid-PLAY, then replay.
    begin_test("reset_mid_play");
    pulse_start();
    repeat (4) @(posedge clock);
    #2;
    check_obs("playing_before_reset", observe(),
              '{freq: 16'h0500, wave: 1'b1, act: 1'b1, busy: 1'b1, done: 1'b0, idx: 2'd0});
    reset = 1'b1;
    #1;
    check_obs("async_reset_values", observe(), rst_obs);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_wave = 1'b1;
    begin_test("replay_after_reset");
    pulse_start();
    push_tone(16'h0500, 1'b1, 3, 2'd0);
    push_end(2'd1);
    wait_drain();

    // Rewrite entry 1 while entry 0 is sounding.
    begin_test("write_during_play");
    write_entry(0, 16'h0600, 1'b0, 16'd2);
    write_entry(1, 16'h0000, 1'b0, 16'd0);
    write_entry(2, 16'h0000, 1'b0, 16'd0);
    pulse_start();
    push_tone(16'h0600, 1'b0, 2, 2'd0);
    push_tone(16'h0300, 1'b1, 1, 2'd1);
    push_end(2'd2);
    repeat (2) @(posedge clock);
    write_entry(1, 16'h0300, 1'b1, 16'd1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a programmed sequence of tones through the CORDIC sine/cosine generator and PWM output stage. Holds a small table of (frequency word, waveform select, duration) entries and steps through them, driving the generator's `freq` and `waveform_sel` inputs with a silent gap between tones. It sits between the board-level control logic and the CORDIC generator. It replaces static switch-driven frequency selection with timed playback.

## Interface
Parameters:
- `freq_width`, 16, width of frequency word (matches CORDIC generator)
- `DEPTH`, 8, table entries (power of two)
- `dur_width`, 16, duration field width, in ticks
- `TICK_DIV`, 50000, clock cycles per duration tick (≥2)
- `GAP_CYCLES`, 1000, silent cycles between tones; 0 disables the gap

Ports:
- `clock`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  $clog2(DEPTH)  table write address
- `wr_freq`  in  freq_width  entry frequency word
- `wr_wave`  in  1  entry waveform select (1 = sine, 0 = cosine)
- `wr_dur`  in  dur_width  entry duration in ticks; 0 = end-of-sequence marker
- `start`  in  1  begin playback from entry 0 (single-cycle pulse)
- `stop`  in  1  abort playback
- `loop`  in  1  restart at entry 0 after the end of the sequence
- `freq`  out  freq_width  to generator `freq`
- `waveform_sel`  out  1  to generator `waveform_sel`
- `tone_active`  out  1  high while a tone is sounding
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on normal sequence completion
- `cur_idx`  out  $clog2(DEPTH)  index of the entry being played

## Operation
- Table: synchronous write, accepted in any state. The entry is latched when it is fetched in LOAD, so a write during playback takes effect at the next fetch of that index.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE → LOAD on `start`, with `cur_idx` = 0.
- LOAD: latch the entry at `cur_idx`.
  - If `dur` ≠ 0: go to PLAY.
  - If `dur` = 0 and `loop` = 1 and `cur_idx` ≠ 0: set `cur_idx` = 0 and stay in LOAD.
  - Otherwise: go to DONE.
  - Entry 0 with `dur` = 0 always goes to DONE, which prevents an infinite loop.
- PLAY: `freq` and `waveform_sel` come from the latched entry; `tone_active` = 1. The tick prescaler clears on entry to PLAY. After exactly `dur` × `TICK_DIV` cycles in PLAY, go to GAP (or directly to the advance step if `GAP_CYCLES` = 0).
- GAP: `freq` = 0, `tone_active` = 0, `waveform_sel` holds its value; lasts exactly `GAP_CYCLES` cycles.
- Advance:
  - If `cur_idx` < DEPTH−1: increment `cur_idx`, go to LOAD.
  - At DEPTH−1 with `loop` = 1: `cur_idx` = 0, go to LOAD.
  - At DEPTH−1 with `loop` = 0: go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `stop` in any non-IDLE state: next state is IDLE and `freq` = 0; no `done` pulse. `stop` takes priority over `start` and over every other transition in the same cycle.
- `start` while `busy` is ignored.
- Duration counter is `dur_width` wide, counts down, and has no wrap. The maximum tone length is (2^dur_width − 1) × `TICK_DIV` cycles.

## Timing
- All outputs are registered.
- Reset values: `freq` = 0, `waveform_sel` = 1, `tone_active` = 0, `busy` = 0, `done` = 0, `cur_idx` = 0, state = IDLE. Table contents are not reset.
- `start` sampled at cycle N: `busy` = 1 at N+1 (LOAD); `freq` is valid and `tone_active` = 1 at N+2.
- Consecutive tones: the last PLAY cycle is followed by `GAP_CYCLES` GAP cycles, 1 LOAD cycle, then PLAY.
- `stop` sampled at cycle N: `busy`, `tone_active` and `freq` are all 0 at N+1.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously).

## Configuration
- `TONE_SEQ_LOOP_EN`
  - Defined: the `loop` input behaves as described above.
  - Undefined: the `loop` port remains but is ignored and treated as 0; sequences always end in DONE and the loop-restart logic is not synthesized.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, PLAY, GAP, DONE);
  - the entry struct {freq, wave, dur};
  - the `TICK_DIV` and `GAP_CYCLES` defaults.
- One sub-module, `tick_prescaler`: a counter modulo `TICK_DIV` with a synchronous clear input and a one-cycle `tick` output.

## Test plan
Bench setting: `TICK_DIV` = 4, `GAP_CYCLES` = 2, `DEPTH` = 4.
- Program entries {0x0100, 1, 3}, {0x0200, 0, 2}, {_, _, 0}; pulse `start` → `freq` = 0x0100 with `waveform_sel` = 1 for 12 cycles, 2 gap cycles with `freq` = 0, 1 LOAD cycle, `freq` = 0x0200 with `waveform_sel` = 0 for 8 cycles, then a single `done` pulse and `busy` = 0.
- All 4 entries have `dur` = 1 and `loop` = 1 (macro defined) → `cur_idx` sequence is 0,1,2,3,0,…; no `done`; `stop` gives `busy` = 0 one cycle later.
- Entry 0 has `dur` = 0, `loop` = 1 → LOAD, then DONE: `done` pulses 2 cycles after `start`; no PLAY state is entered.
- Assert `stop` and `start` in the same cycle during PLAY → IDLE on the next cycle, `freq` = 0, no `done`.
- Assert `reset` in the middle of PLAY → all outputs at reset values asynchronously. After release, a fresh `start` replays the table unchanged.
- Write entry 1 = {0x0300, 1, 1} while entry 0 is playing → entry 1 plays 0x0300.
